rom_port_arbiter: RTL

- Shares the single combinational read port of the instruction ROM between two requesters: instruction fetch (IF) and load/store data-side constant reads (LS).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block registers ROM data, so response latency is exactly 1 cycle after grant.
- Out-of-range and misaligned accesses are rejected with an error flag instead of being aliased.

---
 rtl/rom_port_arbiter_pkg.sv | 44 ++++
 rtl/rom_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/rom_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_pkg
// Shared types, constants and helpers for the instruction-ROM port arbiter.
// The project-wide defines normally come from defs.v; the guarded defaults
// below keep this package self-contained when defs.v is not on the file list.
//   WORDSIZE    : ROM word width
//   ROM_COL_MAX : number of ROM words
//   ARB_PORT_IF : encoding of the instruction-fetch port in owner/rr_last
//   ARB_PORT_LS : encoding of the load/store port in owner/rr_last
// -----------------------------------------------------------------------------
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef ROM_COL_MAX
`define ROM_COL_MAX 256
`endif
`ifndef ARB_PORT_IF
`define ARB_PORT_IF 1'b0
`endif
`ifndef ARB_PORT_LS
`define ARB_PORT_LS 1'b1
`endif

package rom_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

    // Port encodings double as bit positions in the req/gnt vectors.
    localparam logic PORT_IF   = `ARB_PORT_IF;
    localparam logic PORT_LS   = `ARB_PORT_LS;
    localparam int   NUM_PORTS = 2;

    // Misaligned or beyond the last word. The word index is compared rather
    // than the byte address so DEPTH*4 never overflows and 0xFFFFFFFC cannot
    // wrap back into range.
    function automatic logic addr_is_bad(input logic [31:0] addr,
                                         input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. On a tie the port that did not win last time
// is granted; the history register only moves when a grant is actually issued.
//   clk, rst : clock, synchronous active-high reset (history -> LS)
//   req[1:0] : requests, bit index = port encoding
//   en       : arbiter may grant this cycle
//   gnt[1:0] : one-hot grant (all zero when en=0 or no request)
// -----------------------------------------------------------------------------
module rr_arb2
    import rom_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_last_reg;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (rr_last_reg == PORT_LS) ? 2'b01 << PORT_IF : 2'b01 << PORT_LS;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_reg <= PORT_LS;
        end else if (|gnt) begin
            rr_last_reg <= gnt[PORT_LS] ? PORT_LS : PORT_IF;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
// Shares the combinational instruction-ROM read port between instruction
// fetch (IF) and load/store constant reads (LS). One transaction is in flight;
// the ROM word is registered so a response appears one cycle after grant.
// Misaligned or out-of-range addresses return data 0 with the error flag set.
//   clk, rst            : clock, synchronous active-high reset
//   if_req_*/ls_req_*   : valid/ready request channels (ready = grant)
//   if_rsp_*/ls_rsp_*   : valid/ready response channels with data and err
//   rom_addr / rom_data : ROM read port (byte address out, word in)
// -----------------------------------------------------------------------------
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int WORD_W = `WORDSIZE,
    parameter int DEPTH  = `ROM_COL_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [31:0]       if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [WORD_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              if_rsp_ready,
    input  logic              ls_req_valid,
    input  logic [31:0]       ls_req_addr,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [WORD_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    input  logic              ls_rsp_ready,
    output logic [31:0]       rom_addr,
    input  logic [WORD_W-1:0] rom_data
);

    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       req_addr [NUM_PORTS];
    logic [1:0]        gnt;
    logic              grant_en;
    logic              any_gnt;
    logic              winner;
    logic [31:0]       grant_addr;
    logic              grant_err;

    arb_state_e        state_reg;
    logic              owner_reg;
    logic [31:0]       rom_addr_reg;
    logic              rsp_valid_reg [NUM_PORTS];
    logic              rsp_err_reg   [NUM_PORTS];
    logic [WORD_W-1:0] rsp_data_reg  [NUM_PORTS];

    assign req_valid[PORT_IF] = if_req_valid;
    assign req_valid[PORT_LS] = ls_req_valid;
    assign rsp_ready[PORT_IF] = if_rsp_ready;
    assign rsp_ready[PORT_LS] = ls_rsp_ready;
    assign req_addr[PORT_IF]  = if_req_addr;
    assign req_addr[PORT_LS]  = ls_req_addr;

    // A new grant is possible when idle, or when the current owner drains its
    // response this very cycle (zero-bubble hand-over). Reset blocks grants so
    // rr_last is not disturbed by a request that reset is about to discard.
    assign grant_en = !rst && ((state_reg == ST_IDLE) || rsp_ready[owner_reg]);

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (grant_en),
        .gnt (gnt)
    );

    assign any_gnt    = |gnt;
    assign winner     = gnt[PORT_LS] ? PORT_LS : PORT_IF;
    assign grant_addr = req_addr[winner];
    assign grant_err  = addr_is_bad(grant_addr, 32'(DEPTH));

    // The ROM only ever sees a granted address or the previously driven one,
    // so an unqualified (possibly X) request address never reaches it.
    assign rom_addr = any_gnt ? grant_addr : rom_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_reg <= '0;
        end else begin
            rom_addr_reg <= rom_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= PORT_IF;
        end else if (any_gnt) begin
            state_reg <= ST_RESP;
            owner_reg <= winner;
        end else if (state_reg == ST_RESP && rsp_ready[owner_reg]) begin
            state_reg <= ST_IDLE;
        end
    end

    // Per-port response registers. Each port only updates on its own grant,
    // and any grant clears the other port's valid.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
            localparam logic PORT = 1'(gi);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_err_reg[gi]   <= 1'b0;
                    rsp_data_reg[gi]  <= '0;
                end else if (any_gnt) begin
                    rsp_valid_reg[gi] <= gnt[gi];
                    if (gnt[gi]) begin
                        rsp_err_reg[gi]  <= grant_err;
                        rsp_data_reg[gi] <= grant_err ? '0 : rom_data;
                    end
                end else if (state_reg == ST_RESP && owner_reg == PORT && rsp_ready[gi]) begin
                    rsp_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign if_req_ready = gnt[PORT_IF];
    assign ls_req_ready = gnt[PORT_LS];
    assign if_rsp_valid = rsp_valid_reg[PORT_IF];
    assign if_rsp_data  = rsp_data_reg[PORT_IF];
    assign if_rsp_err   = rsp_err_reg[PORT_IF];
    assign ls_rsp_valid = rsp_valid_reg[PORT_LS];
    assign ls_rsp_data  = rsp_data_reg[PORT_LS];
    assign ls_rsp_err   = rsp_err_reg[PORT_LS];

endmodule
